// File: rtl/pe_simd_mac_if.sv
// pe_simd_mac_if: operand, forwarding and result signals of one processing element
interface pe_simd_mac_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W = 72
);
  logic in_vld, first, last;
  logic [2:0] mode;
  logic [DATA_W-1:0] row_in, col_in, row_out, col_out;
  logic vld_out, first_out, last_out;
  logic [2:0] mode_out;
  logic res_vld, res_rdy, res_sat, err_ovf, err_mode;
  logic signed [ACC_W-1:0] res_data;
  modport master (
    output in_vld, first, last, mode, row_in, col_in, res_rdy,
    input row_out, col_out, vld_out, first_out, last_out, mode_out, res_vld, res_data, res_sat, err_ovf, err_mode
  );
  modport slave (
    input in_vld, first, last, mode, row_in, col_in, res_rdy,
    output row_out, col_out, vld_out, first_out, last_out, mode_out, res_vld, res_data, res_sat, err_ovf, err_mode
  );
endinterface

// File: rtl/pe_simd_mac.sv
// pe_simd_mac: systolic PE with operand forwarding and packed-SIMD multiply-accumulate
module pe_simd_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W = 72,
  parameter bit SAT = 1'b1
) (
  input logic clk,
  input logic rst,
  pe_simd_mac_if.slave bus
);
  localparam int NL = DATA_W / 8;
  localparam int PW = 66;
  localparam int SW = PW + $clog2(NL) + 1;
  localparam int TW = (ACC_W > SW ? ACC_W : SW) + 2;
  localparam logic signed [TW-1:0] MAXV = {{(TW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV = ~MAXV;
  logic signed [PW-1:0] prod_d [NL];
  logic signed [PW-1:0] prod [NL];
  logic s1_vld, s1_first, s1_last, sat_acc, clamp, sat_d;
  logic signed [ACC_W-1:0] acc;
  logic signed [SW-1:0] beat_sum;
  logic signed [TW-1:0] total, acc_d;
  function automatic logic signed [32:0] lane(input logic [DATA_W-1:0] v, input int i, input logic [2:0] m);
    logic [DATA_W-1:0] sh;
    logic s;
    sh = v >> (i * (8 << m[2:1]));
    s = ~m[0];
    return m[2:1] == 2'd0 ? {{25{s & sh[7]}}, sh[7:0]} : m[2:1] == 2'd1 ? {{17{s & sh[15]}}, sh[15:0]} : {s & sh[31], sh[31:0]};
  endfunction
  always_comb begin
    for (int i = 0; i < NL; i++)
      prod_d[i] = bus.mode[2:1] != 2'b11 && i < (DATA_W >> (3 + bus.mode[2:1])) ? lane(bus.row_in, i, bus.mode) * lane(bus.col_in, i, bus.mode) : $signed({PW{1'b0}});
  end
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NL; i++) beat_sum = beat_sum + SW'(prod[i]);
    total = (s1_first ? TW'(0) : TW'(acc)) + TW'(beat_sum);
    clamp = SAT && (total > MAXV || total < MINV);
    acc_d = clamp ? (total[TW-1] ? MINV : MAXV) : total;
    sat_d = clamp | (~s1_first & sat_acc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {bus.row_out, bus.col_out, bus.vld_out, bus.first_out, bus.last_out, bus.mode_out} <= '0;
      prod <= '{default: '0};
      {s1_vld, s1_first, s1_last, sat_acc, acc} <= '0;
      {bus.res_vld, bus.res_data, bus.res_sat, bus.err_ovf, bus.err_mode} <= '0;
    end else begin
      {bus.row_out, bus.col_out, bus.vld_out, bus.first_out, bus.last_out, bus.mode_out} <= {bus.row_in, bus.col_in, bus.in_vld, bus.first, bus.last, bus.mode};
      prod <= prod_d;
      {s1_vld, s1_first, s1_last} <= {bus.in_vld, bus.in_vld & bus.first, bus.in_vld & bus.last};
      bus.err_mode <= bus.err_mode | (bus.in_vld & (bus.mode[2:1] == 2'b11));
      if (s1_vld) {acc, sat_acc} <= {ACC_W'(acc_d), sat_d};
      if (s1_last && (!bus.res_vld || bus.res_rdy)) {bus.res_vld, bus.res_data, bus.res_sat} <= {1'b1, ACC_W'(acc_d), sat_d};
      else if (bus.res_rdy) bus.res_vld <= 1'b0;
      bus.err_ovf <= bus.err_ovf | (s1_last & bus.res_vld & ~bus.res_rdy);
    end
  end
endmodule

// File: tb/tb_pe_simd_mac.sv
// tb_pe_simd_mac: scenario tasks plus randomized beats checked against an arithmetic reference model
module tb_pe_simd_mac;
  logic clk = 1'b0, rst = 1'b1;
  logic in_vld = 1'b0, first = 1'b0, last = 1'b0, res_rdy = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [63:0] row = '0, col = '0;
  int n_cmp = 0, n_bad = 0;
  logic o_vld [4], o_sat [4], o_ovf [4], o_emode [4];
  logic [2:0] o_fwd [4], o_mode [4];
  logic signed [127:0] o_data [4];
  logic [63:0] o_row [4], o_col [4];
  always #5 clk = ~clk;
  pe_simd_mac_if #(.DATA_W(32), .ACC_W(72)) b0 ();
  pe_simd_mac_if #(.DATA_W(32), .ACC_W(16)) b1 ();
  pe_simd_mac_if #(.DATA_W(32), .ACC_W(16)) b2 ();
  pe_simd_mac_if #(.DATA_W(64), .ACC_W(72)) b3 ();
  pe_simd_mac #(.DATA_W(32), .ACC_W(72), .SAT(1'b1)) d0 (.clk(clk), .rst(rst), .bus(b0));
  pe_simd_mac #(.DATA_W(32), .ACC_W(16), .SAT(1'b1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  pe_simd_mac #(.DATA_W(32), .ACC_W(16), .SAT(1'b0)) d2 (.clk(clk), .rst(rst), .bus(b2));
  pe_simd_mac #(.DATA_W(64), .ACC_W(72), .SAT(1'b1)) d3 (.clk(clk), .rst(rst), .bus(b3));
  assign {b0.in_vld, b0.first, b0.last, b0.mode, b0.res_rdy, b0.row_in, b0.col_in} = {in_vld, first, last, mode, res_rdy, row[31:0], col[31:0]};
  assign {b1.in_vld, b1.first, b1.last, b1.mode, b1.res_rdy, b1.row_in, b1.col_in} = {in_vld, first, last, mode, res_rdy, row[31:0], col[31:0]};
  assign {b2.in_vld, b2.first, b2.last, b2.mode, b2.res_rdy, b2.row_in, b2.col_in} = {in_vld, first, last, mode, res_rdy, row[31:0], col[31:0]};
  assign {b3.in_vld, b3.first, b3.last, b3.mode, b3.res_rdy, b3.row_in, b3.col_in} = {in_vld, first, last, mode, res_rdy, row, col};
  assign {o_vld[0], o_sat[0], o_ovf[0], o_emode[0], o_fwd[0], o_mode[0]} = {b0.res_vld, b0.res_sat, b0.err_ovf, b0.err_mode, b0.vld_out, b0.first_out, b0.last_out, b0.mode_out};
  assign {o_vld[1], o_sat[1], o_ovf[1], o_emode[1], o_fwd[1], o_mode[1]} = {b1.res_vld, b1.res_sat, b1.err_ovf, b1.err_mode, b1.vld_out, b1.first_out, b1.last_out, b1.mode_out};
  assign {o_vld[2], o_sat[2], o_ovf[2], o_emode[2], o_fwd[2], o_mode[2]} = {b2.res_vld, b2.res_sat, b2.err_ovf, b2.err_mode, b2.vld_out, b2.first_out, b2.last_out, b2.mode_out};
  assign {o_vld[3], o_sat[3], o_ovf[3], o_emode[3], o_fwd[3], o_mode[3]} = {b3.res_vld, b3.res_sat, b3.err_ovf, b3.err_mode, b3.vld_out, b3.first_out, b3.last_out, b3.mode_out};
  assign o_data[0] = 128'(b0.res_data);
  assign o_data[1] = 128'(b1.res_data);
  assign o_data[2] = 128'(b2.res_data);
  assign o_data[3] = 128'(b3.res_data);
  assign {o_row[0], o_col[0]} = {32'd0, b0.row_out, 32'd0, b0.col_out};
  assign {o_row[1], o_col[1]} = {32'd0, b1.row_out, 32'd0, b1.col_out};
  assign {o_row[2], o_col[2]} = {32'd0, b2.row_out, 32'd0, b2.col_out};
  assign {o_row[3], o_col[3]} = {b3.row_out, b3.col_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic [2:0] m, input logic [63:0] r, input logic [63:0] c);
    {in_vld, first, last, mode, row, col} = {1'b1, f, l, m, r, c};
    step();
    in_vld = 1'b0;
  endtask

  function automatic logic signed [127:0] beat_model(input logic [63:0] r, input logic [63:0] c, input logic [2:0] m, input int dw);
    int e;
    logic signed [127:0] s, a, b;
    if (m >= 3'd6) return 128'sd0;
    e = 8 << (m / 2);
    s = 0;
    for (int i = 0; i < dw / e; i++) begin
      a = (r >> (i * e)) & ((128'd1 << e) - 1);
      b = (c >> (i * e)) & ((128'd1 << e) - 1);
      if (!m[0] && a[e-1]) a = a - (128'sd1 <<< e);
      if (!m[0] && b[e-1]) b = b - (128'sd1 <<< e);
      s = s + a * b;
    end
    return s;
  endfunction

  function automatic logic signed [127:0] fit(input logic signed [127:0] v, input int aw, input bit s, output bit c);
    logic signed [127:0] mx;
    mx = (128'sd1 <<< (aw - 1)) - 1;
    c = s && (v > mx || v < -mx - 1);
    if (!s) return (v <<< (128 - aw)) >>> (128 - aw);
    return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    {in_vld, first, last, mode, row, col, res_rdy} = {1'b1, 1'b1, 1'b1, 3'd4, 64'h1234, 64'h5678, 1'b1};
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({o_vld[k], o_sat[k], o_ovf[k], o_emode[k], o_fwd[k], o_mode[k]} !== 9'd0 || o_data[k] !== 0 || o_row[k] !== 0 || o_col[k] !== 0) begin
        n_bad++;
        $display("FAIL reset dut%0d got vld=%b data=%0d row=%h fwd=%b flags=%b%b exp all zero", k, o_vld[k], o_data[k], o_row[k], o_fwd[k], o_ovf[k], o_emode[k]);
      end
    end
    {in_vld, first, last} = 3'b000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    res_rdy = 1'b1;
    drive(1'b1, 1'b1, 3'd4, 64'd2, 64'd3);
    n_cmp++; if (o_row[0] !== 64'd2 || o_col[0] !== 64'd3) begin n_bad++; $display("FAIL fwd_rowcol got %0d/%0d exp 2/3", o_row[0], o_col[0]); end
    n_cmp++; if (o_fwd[0] !== 3'b111 || o_mode[0] !== 3'd4) begin n_bad++; $display("FAIL fwd_tags got %b mode %0d exp 111 mode 4", o_fwd[0], o_mode[0]); end
    n_cmp++; if (o_vld[0] !== 1'b0) begin n_bad++; $display("FAIL single_early got res_vld=%b exp 0", o_vld[0]); end
    step();
    n_cmp++; if (o_fwd[0] !== 3'b011) begin n_bad++; $display("FAIL fwd_idle got %b exp 011", o_fwd[0]); end
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== 6) begin n_bad++; $display("FAIL single got vld=%b data=%0d exp 1/6", o_vld[0], o_data[0]); end
    step();
    n_cmp++; if (o_vld[0] !== 1'b0) begin n_bad++; $display("FAIL single_drop got res_vld=%b exp 0", o_vld[0]); end
  endtask

  task automatic test_chain();
    logic [63:0] r4 [4] = '{64'd2, 64'd10, 64'd7, 64'd5};
    logic [63:0] c4 [4] = '{64'd3, 64'd11, 64'd8, 64'd6};
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, i == 3, 3'd4, r4[i], c4[i]);
      n_cmp++; if (o_vld[0] !== 1'b0) begin n_bad++; $display("FAIL chain_early beat%0d got res_vld=%b exp 0", i, o_vld[0]); end
    end
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_vld[k] !== 1'b1 || o_data[k] !== 202) begin n_bad++; $display("FAIL chain dut%0d got vld=%b data=%0d exp 1/202", k, o_vld[k], o_data[k]); end
    end
    step();
  endtask

  task automatic test_lanes();
    logic [63:0] rs [3] = '{64'h01020304, 64'hFF, 64'hFF};
    logic [63:0] cs [3] = '{64'h05060708, 64'h2, 64'h2};
    logic [2:0] ms [3] = '{3'd0, 3'd0, 3'd1};
    int ex [3] = '{70, -2, 510};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, ms[i], rs[i], cs[i]);
      step();
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (o_vld[k] !== 1'b1 || o_data[k] !== ex[i]) begin n_bad++; $display("FAIL lanes%0d dut%0d got vld=%b data=%0d exp 1/%0d", i, k, o_vld[k], o_data[k], ex[i]); end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int ex [3] = '{6, 110, 56};
    res_rdy = 1'b1;
    drive(1'b1, 1'b1, 3'd4, 64'd2, 64'd3);
    drive(1'b1, 1'b1, 3'd4, 64'd10, 64'd11);
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== ex[0]) begin n_bad++; $display("FAIL b2b0 got vld=%b data=%0d exp 1/%0d", o_vld[0], o_data[0], ex[0]); end
    drive(1'b1, 1'b1, 3'd4, 64'd7, 64'd8);
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== ex[1]) begin n_bad++; $display("FAIL b2b1 got vld=%b data=%0d exp 1/%0d", o_vld[0], o_data[0], ex[1]); end
    step();
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== ex[2]) begin n_bad++; $display("FAIL b2b2 got vld=%b data=%0d exp 1/%0d", o_vld[0], o_data[0], ex[2]); end
    n_cmp++; if (o_ovf[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got %b exp 0", o_ovf[0]); end
    step();
    n_cmp++; if (o_vld[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_end got res_vld=%b exp 0", o_vld[0]); end
  endtask

  task automatic test_random();
    int dw [4] = '{32, 32, 32, 64};
    int aw [4] = '{72, 16, 16, 72};
    bit sm [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic signed [127:0] acc [4];
    bit sf [4];
    logic signed [127:0] q_d [4][$];
    bit q_s [4][$];
    logic signed [127:0] ed;
    bit es, c;
    logic [63:0] msk;
    rst = 1'b1;
    step();
    rst = 1'b0;
    res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin acc[k] = 0; sf[k] = 1'b0; end
    for (int n = 0; n < 400; n++) begin
      in_vld = $urandom_range(3) != 0;
      first = 1'($urandom_range(1));
      last = $urandom_range(2) == 0;
      mode = 3'($urandom_range(5));
      row = $urandom_range(3) == 0 ? {2{32'h80808080}} : {$urandom, $urandom};
      col = $urandom_range(3) == 0 ? {2{32'h7F7F8001}} : {$urandom, $urandom};
      if (in_vld) begin
        for (int k = 0; k < 4; k++) begin
          acc[k] = fit((first ? 128'sd0 : acc[k]) + beat_model(row, col, mode, dw[k]), aw[k], sm[k], c);
          sf[k] = first ? c : sf[k] | c;
          if (last) begin q_d[k].push_back(acc[k]); q_s[k].push_back(sf[k]); end
        end
      end
      step();
      for (int k = 0; k < 4; k++) begin
        msk = dw[k] == 64 ? ~64'd0 : 64'hFFFFFFFF;
        n_cmp++; if (o_row[k] !== (row & msk) || o_fwd[k] !== {in_vld, first, last} || o_mode[k] !== mode) begin n_bad++; $display("FAIL rnd_fwd dut%0d n%0d got row=%h tags=%b exp row=%h tags=%b", k, n, o_row[k], o_fwd[k], row & msk, {in_vld, first, last}); end
        if (o_vld[k]) begin
          n_cmp++;
          if (q_d[k].size() == 0) begin
            n_bad++; $display("FAIL rnd_extra dut%0d n%0d got unexpected result %0d", k, n, o_data[k]);
          end else begin
            ed = q_d[k].pop_front();
            es = q_s[k].pop_front();
            if (o_data[k] !== ed || o_sat[k] !== es) begin n_bad++; $display("FAIL rnd_res dut%0d n%0d got %0d sat %b exp %0d sat %b", k, n, o_data[k], o_sat[k], ed, es); end
          end
        end
      end
      in_vld = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      step();
      for (int k = 0; k < 4; k++) if (o_vld[k]) begin
        n_cmp++;
        ed = q_d[k].size() != 0 ? q_d[k].pop_front() : 128'sd0;
        es = q_s[k].size() != 0 ? q_s[k].pop_front() : 1'b0;
        if (o_data[k] !== ed || o_sat[k] !== es) begin n_bad++; $display("FAIL rnd_tail dut%0d got %0d sat %b exp %0d sat %b", k, o_data[k], o_sat[k], ed, es); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (q_d[k].size() != 0 || o_ovf[k] !== 1'b0) begin n_bad++; $display("FAIL rnd_left dut%0d got %0d pending ovf=%b exp 0 pending ovf=0", k, q_d[k].size(), o_ovf[k]); end
    end
  endtask

  task automatic test_backpressure();
    res_rdy = 1'b0;
    drive(1'b1, 1'b1, 3'd4, 64'd2, 64'd3);
    step();
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== 6) begin n_bad++; $display("FAIL bp_first got vld=%b data=%0d exp 1/6", o_vld[0], o_data[0]); end
    drive(1'b1, 1'b1, 3'd4, 64'd10, 64'd11);
    step();
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== 6) begin n_bad++; $display("FAIL bp_hold got vld=%b data=%0d exp 1/6", o_vld[0], o_data[0]); end
    n_cmp++; if (o_ovf[0] !== 1'b1) begin n_bad++; $display("FAIL bp_ovf got %b exp 1", o_ovf[0]); end
    res_rdy = 1'b1;
    step();
    n_cmp++; if (o_vld[0] !== 1'b0 || o_ovf[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release got vld=%b ovf=%b exp 0/1", o_vld[0], o_ovf[0]); end
  endtask

  task automatic test_saturation();
    res_rdy = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 64'h7F7F7F7F, 64'h7F7F7F7F);
    step();
    n_cmp++; if (o_data[1] !== 32767 || o_sat[1] !== 1'b1) begin n_bad++; $display("FAIL sat_clamp got %0d sat %b exp 32767 sat 1", o_data[1], o_sat[1]); end
    n_cmp++; if (o_data[2] !== -1020 || o_sat[2] !== 1'b0) begin n_bad++; $display("FAIL sat_wrap got %0d sat %b exp -1020 sat 0", o_data[2], o_sat[2]); end
    n_cmp++; if (o_data[0] !== 64516 || o_sat[0] !== 1'b0) begin n_bad++; $display("FAIL sat_wide got %0d sat %b exp 64516 sat 0", o_data[0], o_sat[0]); end
    drive(1'b1, 1'b1, 3'd4, 64'd2, 64'd3);
    step();
    n_cmp++; if (o_data[1] !== 6 || o_sat[1] !== 1'b0) begin n_bad++; $display("FAIL sat_clear got %0d sat %b exp 6 sat 0", o_data[1], o_sat[1]); end
  endtask

  task automatic test_mode_err();
    n_cmp++; if (o_emode[0] !== 1'b0) begin n_bad++; $display("FAIL mode_pre got %b exp 0", o_emode[0]); end
    drive(1'b1, 1'b0, 3'd4, 64'd2, 64'd3);
    drive(1'b0, 1'b1, 3'd6, 64'd5, 64'd7);
    n_cmp++; if (o_emode[0] !== 1'b1) begin n_bad++; $display("FAIL mode_flag got %b exp 1", o_emode[0]); end
    step();
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== 6) begin n_bad++; $display("FAIL mode_zero got vld=%b data=%0d exp 1/6", o_vld[0], o_data[0]); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 3'd4, 64'd9, 64'd9);
    {in_vld, first, last, mode, row, col} = {1'b1, 1'b0, 1'b1, 3'd4, 64'd4, 64'd4};
    rst = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({o_vld[k], o_sat[k], o_ovf[k], o_emode[k], o_fwd[k], o_mode[k]} !== 9'd0 || o_data[k] !== 0 || o_row[k] !== 0) begin
        n_bad++; $display("FAIL rst_mid dut%0d got vld=%b data=%0d ovf=%b emode=%b fwd=%b exp all zero", k, o_vld[k], o_data[k], o_ovf[k], o_emode[k], o_fwd[k]);
      end
    end
    rst = 1'b0;
    in_vld = 1'b0;
    step();
    step();
    n_cmp++; if (o_vld[0] !== 1'b0) begin n_bad++; $display("FAIL rst_discard got res_vld=%b exp 0", o_vld[0]); end
    drive(1'b0, 1'b1, 3'd4, 64'd2, 64'd3);
    step();
    n_cmp++; if (o_vld[0] !== 1'b1 || o_data[0] !== 6) begin n_bad++; $display("FAIL rst_acc got vld=%b data=%0d exp 1/6", o_vld[0], o_data[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_lanes();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_saturation();
    test_mode_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_simd_mac.md
Name: pe_simd_mac

Overview:
- Next-generation processing element for the systolic matrix-multiply array.
- Forwards row/column operands to its neighbours one cycle later and performs a packed-SIMD multiply-accumulate with a runtime-selectable element type.
- Accumulates over a first/last-framed sequence of beats.
- Presents each finished dot product on a valid/ready result port with optional saturation and sticky error flags.

Parameters:
- DATA_W, 32: operand width; legal values 32 or 64.
- ACC_W, 72: signed accumulator/result width; minimum 16.
- SAT, 1: 1 = clamp the accumulator to the signed ACC_W range; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  operand beat valid.
- first  in  1  beat starts a new accumulation (qualified by in_vld).
- last  in  1  beat ends the accumulation (qualified by in_vld).
- mode  in  3  element type for this beat.
- row_in  in  DATA_W  row operand.
- col_in  in  DATA_W  column operand.
- row_out  out  DATA_W  row_in registered.
- col_out  out  DATA_W  col_in registered.
- vld_out  out  1  in_vld registered.
- first_out  out  1  first registered.
- last_out  out  1  last registered.
- mode_out  out  3  mode registered.
- res_vld  out  1  result valid.
- res_rdy  in  1  result accepted by the drain path.
- res_data  out  ACC_W  signed result.
- res_sat  out  1  saturation occurred in this result.
- err_ovf  out  1  sticky: a result was dropped.
- err_mode  out  1  sticky: an illegal mode was seen.

Behaviour:
- Reset: every output and all internal registers are 0 in the cycle after rst is sampled high. Reset mid-accumulation discards all partial state and any pending result.
- Forwarding: row_out, col_out, vld_out, first_out, last_out and mode_out equal their inputs delayed exactly 1 cycle. These are unconditional: they are not gated by in_vld or by result backpressure.
- Mode encoding:
  - 000 int8, 001 uint8: DATA_W/8 lanes.
  - 010 int16, 011 uint16: DATA_W/16 lanes.
  - 100 int32, 101 uint32: DATA_W/32 lanes.
  - 110 and 111 are illegal: the beat's contribution is 0 and err_mode is set.
  - Lane i occupies bits [i*E +: E], where E is the element width.
- Lane product: row lane × col lane, sign- or zero-extended per mode. Beat sum is the sum of all lane products, computed at full precision and never truncated before accumulation.
- Pipeline:
  - S1 registers the lane products plus the first/last/vld tags.
  - S2 reduces the products and updates the accumulator.
  - A beat accepted at cycle t affects the accumulator at t+2.
  - If the beat carries last, res_vld rises at t+2.
- Accumulation rules:
  - first=1: acc = beat_sum.
  - first=0: acc = acc + beat_sum.
  - first and last together yield that single beat's sum.
  - The accumulator holds its value after last. A following beat without first continues from it (chaining).
  - mode may change between beats; each beat uses its own mode.
- Saturation:
  - SAT=1: the sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A per-accumulation sat flag is set on any clamp and cleared by first. res_sat shows that flag's value as of the last beat.
  - SAT=0: the sum wraps and res_sat stays 0.
- Result handshake:
  - res_data, res_sat and res_vld are held stable while res_vld=1 and res_rdy=0.
  - The transfer occurs on a cycle with res_vld and res_rdy both high. res_vld drops next cycle unless a new result is loaded in the same cycle; that same-cycle transfer-and-load is legal and produces no error.
  - A new result completing while res_vld=1 and res_rdy=0 is dropped: the old result is kept and err_ovf is set.
- Error flags: err_ovf and err_mode clear only on rst.
- Input rules: in_vld=0 beats never alter the accumulator. first and last are ignored when in_vld=0.

Test Plan:
- Reset hold then release; mode=100, first=last=1, row=2, col=3 at cycle t, res_rdy=1 → res_vld at t+2 with res_data=6. row_out/col_out = 2/3 at t+1, vld_out=1 at t+1.
- mode=100, four beats (2,3), (10,11), (7,8), (5,6), with first on beat 1 and last on beat 4 → single result 202; no res_vld before the last beat's t+2.
- Packed lanes, row=0x01020304, col=0x05060708, first=last=1:
  - mode=000 → 70.
  - Then row=0x000000FF, col=0x00000002: mode=000 → -2, mode=001 → 510.
- Backpressure: res_rdy=0, two single-beat accumulations of 6 then 110 → res_data stays 6, err_ovf=1. Raising res_rdy transfers 6, then res_vld falls.
- SAT=1, ACC_W=16, mode=000, row=col=0x7F7F7F7F, first=last=1 → res_data=32767, res_sat=1. The next first/last beat of 2×3 → 6, res_sat=0.
- mode=110 beat → err_mode=1, contributes 0. Assert rst mid-accumulation → all outputs 0 next cycle, and the flags clear.
